// File: rtl/alu_exec.sv
// Sequential ALU: single-cycle arithmetic/logic, bit-serial SHL/SHR (k cycles), shift-add MUL (16 cycles).
// Results and flags are registered and update only with the done pulse; start is ignored while busy.
module alu_exec #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow,
   output logic             busy,
   output logic             done,
   output logic             err
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOTA = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_PASB = 4'd9;

   typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [2*WIDTH-1:0]   p_q, p_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 dir_q, dir_d;

   logic [WIDTH-1:0]     res_q, res_hi_q;
   logic                 zero_q, carry_q, neg_q, ovf_q, done_q, err_q;

   logic                 fin, fin_c, fin_v, fin_err, fin_z, fin_n;
   logic [WIDTH-1:0]     fin_lo, fin_hi;
   logic [WIDTH:0]       add_w, sub_w, mul_sum;
   logic [WIDTH-1:0]     sh_val;
   logic                 sh_out;

   assign add_w   = {1'b0, opa} + {1'b0, opb};
   assign sub_w   = {1'b0, opa} - {1'b0, opb};
   assign sh_val  = dir_q ? {1'b0, a_q[WIDTH-1:1]} : {a_q[WIDTH-2:0], 1'b0};
   assign sh_out  = dir_q ? a_q[0] : a_q[WIDTH-1];
   // Product register holds {partial sum, remaining multiplier bits}; one add-and-shift per cycle.
   assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      fin     = 1'b0;
      fin_lo  = '0;
      fin_hi  = '0;
      fin_c   = 1'b0;
      fin_v   = 1'b0;
      fin_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               fin = 1'b1;
               case (opcode)
                  OP_ADD: begin
                     fin_lo = add_w[WIDTH-1:0];
                     fin_c  = add_w[WIDTH];
                     fin_v  = (opa[WIDTH-1] == opb[WIDTH-1]) && (add_w[WIDTH-1] != opa[WIDTH-1]);
                  end
                  OP_SUB: begin
                     fin_lo = sub_w[WIDTH-1:0];
                     fin_c  = sub_w[WIDTH];
                     fin_v  = (opa[WIDTH-1] != opb[WIDTH-1]) && (sub_w[WIDTH-1] != opa[WIDTH-1]);
                  end
                  OP_AND:  fin_lo = opa & opb;
                  OP_OR:   fin_lo = opa | opb;
                  OP_XOR:  fin_lo = opa ^ opb;
                  OP_NOTA: fin_lo = ~opa;
                  OP_SHL, OP_SHR: begin
                     if (opb[CW-1:0] == '0) begin
                        fin_lo = opa;
                     end else begin
                        fin     = 1'b0;
                        state_d = SHIFT;
                        a_d     = opa;
                        cnt_d   = opb[CW-1:0];
                        dir_d   = (opcode == OP_SHR);
                     end
                  end
                  OP_MUL: begin
                     fin     = 1'b0;
                     state_d = MUL;
                     a_d     = opa;
                     p_d     = {{WIDTH{1'b0}}, opb};
                     cnt_d   = '1;
                  end
                  OP_PASB: fin_lo = opb;
                  default: fin_err = 1'b1;
               endcase
            end
         end
         SHIFT: begin
            a_d   = sh_val;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               fin     = 1'b1;
               fin_lo  = sh_val;
               fin_c   = sh_out;
               state_d = IDLE;
            end
         end
         MUL: begin
            p_d   = {mul_sum, p_q[WIDTH-1:1]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               fin     = 1'b1;
               fin_hi  = mul_sum[WIDTH:1];
               fin_lo  = {mul_sum[0], p_q[WIDTH-1:1]};
               fin_c   = |mul_sum[WIDTH:1];
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // An illegal opcode reports an all-zero result but must not raise the zero flag.
   assign fin_z = ~fin_err & ~|{fin_hi, fin_lo};
   assign fin_n = fin_lo[WIDTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         p_q      <= '0;
         cnt_q    <= '0;
         dir_q    <= 1'b0;
         res_q    <= '0;
         res_hi_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         done_q  <= fin;
         err_q   <= fin_err;
         if (fin) begin
            res_q    <= fin_lo;
            res_hi_q <= fin_hi;
            zero_q   <= fin_z;
            carry_q  <= fin_c;
            neg_q    <= fin_n;
            ovf_q    <= fin_v;
         end
      end
   end

   assign result    = res_q;
   assign result_hi = res_hi_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign negative  = neg_q;
   assign overflow  = ovf_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign err       = err_q;
endmodule

// File: tb/tb_alu_exec.sv
// Directed and random checks of alu_exec against an arithmetic reference model.
module tb_alu_exec;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  opcode;
   logic [15:0] opa, opb;
   logic [15:0] result, result_hi;
   logic        zero, carry, negative, overflow, busy, done, err;

   int total = 0;
   int bad   = 0;

   logic [15:0] e_lo = '0, e_hi = '0;
   logic        e_z = 1'b0, e_c = 1'b0, e_n = 1'b0, e_v = 1'b0;

   alu_exec #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .opa(opa), .opb(opb),
      .result(result), .result_hi(result_hi), .zero(zero), .carry(carry),
      .negative(negative), .overflow(overflow), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected outcome and completion latency (edges after the accepting edge).
   task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] lo, output logic [15:0] hi,
                        output logic z, output logic c, output logic n, output logic v,
                        output logic e, output int lat);
      int     sa, sb, r, k;
      longint p;
      lo = '0; hi = '0; c = 1'b0; v = 1'b0; e = 1'b0; lat = 0;
      sa = $signed(a);
      sb = $signed(b);
      k  = int'(b[3:0]);
      case (op)
         4'd0: begin
            r = int'(a) + int'(b);
            lo = r[15:0]; c = r[16];
            v = (sa + sb > 32767) || (sa + sb < -32768);
         end
         4'd1: begin
            r = int'(a) - int'(b);
            lo = r[15:0]; c = (a < b);
            v = (sa - sb > 32767) || (sa - sb < -32768);
         end
         4'd2: lo = a & b;
         4'd3: lo = a | b;
         4'd4: lo = a ^ b;
         4'd5: lo = ~a;
         4'd6: begin
            r = int'(a) << k;
            lo = r[15:0]; c = (k != 0) ? r[16] : 1'b0; lat = k;
         end
         4'd7: begin
            lo = a >> k; lat = k;
            if (k != 0) c = a[k-1];
         end
         4'd8: begin
            p = longint'(a) * longint'(b);
            lo = p[15:0]; hi = p[31:16]; c = (hi != 0); lat = 16;
         end
         4'd9: lo = b;
         default: e = 1'b1;
      endcase
      z = e ? 1'b0 : ({hi, lo} == 32'd0);
      n = lo[15];
   endtask

   // Called just after a clock edge; leaves the bench just after the done edge.
   task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int mid_pulse, input bit hold_end);
      logic [15:0] lo, hi;
      logic        z, c, n, v, e;
      int          lat;
      model(op, a, b, lo, hi, z, c, n, v, e, lat);
      start = 1'b1; opcode = op; opa = a; opb = b;
      @(posedge clk); #1;
      start = 1'b0; opa = 16'($urandom); opb = 16'($urandom); opcode = 4'($urandom);
      for (int i = 0; i < lat; i++) begin
         chk("busy_during_op", busy, 1);
         chk("no_early_done", done, 0);
         chk("result_held", result, e_lo);
         chk("carry_held", carry, e_c);
         start = (i == mid_pulse) || (hold_end && i == lat - 1);
         if (start) opcode = 4'd0;
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("done", done, 1);
      chk("err", err, e);
      chk("busy_at_done", busy, 0);
      chk("result", result, lo);
      chk("result_hi", result_hi, hi);
      chk("zero", zero, z);
      chk("carry", carry, c);
      chk("negative", negative, n);
      chk("overflow", overflow, v);
      e_lo = lo; e_hi = hi; e_z = z; e_c = c; e_n = n; e_v = v;
      if (hold_end) begin
         @(posedge clk); #1;
         chk("start_ignored_at_completion", done, 0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_result_hi"}, result_hi, 0);
      chk({tag, "_flags"}, {zero, carry, negative, overflow}, 0);
      chk({tag, "_busy_done_err"}, {busy, done, err}, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; opcode = '0; opa = '0; opb = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      do_op(4'd0, 16'h7FFF, 16'h0001, -1, 1'b0);
      do_op(4'd1, 16'h0003, 16'h0005, -1, 1'b0);
      do_op(4'd2, 16'hF0F0, 16'h0FF0, -1, 1'b0);
      do_op(4'd6, 16'h8001, 16'h0004, -1, 1'b1);
      do_op(4'd6, 16'h8001, 16'h0000, -1, 1'b0);
      do_op(4'd7, 16'h0003, 16'h0001, -1, 1'b0);
      do_op(4'd8, 16'h0100, 16'h0100, 5, 1'b0);
      do_op(4'hF, 16'h1234, 16'h5678, -1, 1'b0);
      do_op(4'd9, 16'hBEEF, 16'hCAFE, -1, 1'b0);

      // Abort a multiply part-way with an asynchronous reset.
      start = 1'b1; opcode = 4'd8; opa = 16'h00FF; opb = 16'h0F0F;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("async_abort");
      @(posedge clk); #1;
      rst = 1'b0;
      e_lo = '0; e_hi = '0; e_z = 1'b0; e_c = 1'b0; e_n = 1'b0; e_v = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk("no_done_after_abort", done, 0);
         @(posedge clk); #1;
      end
      do_op(4'd0, 16'h0002, 16'h0003, -1, 1'b0);

      for (int t = 0; t < 50; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            chk("idle_no_done", done, 0);
         end
         do_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), -1, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
